// File: rtl/spio_spl_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spio_spl_pkt_arbiter
// Purpose  : 4-port round-robin packet arbiter feeding a one-entry output
//            register; optional parity drop with SPIO_ARB_PARITY_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spio_spl_pkt_arbiter #(
  parameter int PKT_BITS = 72,
  parameter int NPORTS   = 4
) (
  input  logic                       tb_clk,
  input  logic                       tb_rst,
  input  logic [NPORTS*PKT_BITS-1:0] PKT_DATA_IN,
  input  logic [NPORTS-1:0]          PKT_VLD_IN,
  output logic [NPORTS-1:0]          PKT_RDY_OUT,
  output logic [PKT_BITS-1:0]        PKT_DATA_OUT,
  output logic                       PKT_VLD_OUT,
  input  logic                       PKT_RDY_IN,
  output logic [NPORTS-1:0]          GNT_OUT,
  output logic [15:0]                PRTY_ERR_CNT_OUT
);

  localparam int IDXW    = $clog2(NPORTS);
  localparam int HDR_SEL = 1;   // hdr bit that brings the payload into parity
  localparam int KEY_MSB = 39;
  localparam int PAY_LSB = 40;
  localparam int PAY_MSB = 71;

  logic [IDXW-1:0]     last_gnt_q, last_gnt_d;
  logic [IDXW-1:0]     sel_idx;
  logic                sel_any;
  logic [NPORTS-1:0]   sel_oh;
  logic [PKT_BITS-1:0] sel_pkt;
  logic                space;
  logic                xfer;
  logic                pkt_good;

  logic [PKT_BITS-1:0] data_q, data_d;
  logic                vld_q, vld_d;
  logic [NPORTS-1:0]   gnt_q, gnt_d;

  // Scan from last_gnt+1 upward; iterating downward lets the nearest port win.
  always_comb begin
    logic [IDXW-1:0] scan_idx;
    scan_idx = '0;
    sel_idx  = last_gnt_q;
    sel_any  = 1'b0;
    for (int k = NPORTS; k >= 1; k--) begin
      scan_idx = last_gnt_q + IDXW'(k);
      if (PKT_VLD_IN[scan_idx]) begin
        sel_idx = scan_idx;
        sel_any = 1'b1;
      end
    end
  end

  assign sel_oh      = sel_any ? (NPORTS'(1) << sel_idx) : '0;
  assign sel_pkt     = PKT_DATA_IN[sel_idx*PKT_BITS +: PKT_BITS];
  assign space       = ~vld_q | PKT_RDY_IN;
  assign PKT_RDY_OUT = (space && !tb_rst) ? sel_oh : '0;
  assign xfer        = |(PKT_VLD_IN & PKT_RDY_OUT);

`ifdef SPIO_ARB_PARITY_CHK_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  assign pkt_good = (^sel_pkt[KEY_MSB:0]) ^
                    (sel_pkt[HDR_SEL] & (^sel_pkt[PAY_MSB:PAY_LSB]));

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (xfer && !pkt_good && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign PRTY_ERR_CNT_OUT = err_cnt_q;
`else
  assign pkt_good         = 1'b1;
  assign PRTY_ERR_CNT_OUT = '0;
`endif

  // Bad-parity packets still complete the handshake and advance the pointer.
  always_comb begin
    last_gnt_d = last_gnt_q;
    data_d     = data_q;
    vld_d      = vld_q;
    gnt_d      = gnt_q;
    if (xfer) begin
      last_gnt_d = sel_idx;
    end
    if (xfer && pkt_good) begin
      data_d = sel_pkt;
      vld_d  = 1'b1;
      gnt_d  = sel_oh;
    end else if (vld_q && PKT_RDY_IN) begin
      vld_d  = 1'b0;
      gnt_d  = '0;
    end
  end

  always_ff @(posedge tb_clk or posedge tb_rst) begin
    if (tb_rst) begin
      last_gnt_q <= IDXW'(NPORTS - 1);
      data_q     <= '0;
      vld_q      <= 1'b0;
      gnt_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      gnt_q      <= gnt_d;
    end
  end

  assign PKT_DATA_OUT = data_q;
  assign PKT_VLD_OUT  = vld_q;
  assign GNT_OUT      = gnt_q;

endmodule
`default_nettype wire
